// File: rtl/motor_pwm_bridge.sv
// motor_pwm_bridge: dual H-bridge PWM with slew-limited ramping, reversal through zero and dead time; MOTOR_PWM_BRAKE_EN selects short-brake at zero magnitude
module motor_pwm_bridge #(
    parameter int PRESC        = 50,
    parameter int RAMP_PERIODS = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] cmd_izq,
    input  logic [7:0] cmd_der,
    output logic       izq_in1,
    output logic       izq_in2,
    output logic       der_in1,
    output logic       der_in2,
    output logic       busy_izq,
    output logic       busy_der
);
    localparam logic [15:0] PRESC_MAX = 16'(PRESC - 1);
    localparam logic [15:0] RAMP_MAX  = 16'(RAMP_PERIODS - 1);
    localparam logic [7:0]  DEAD_LD   = 8'(DEAD_PERIODS - 1);
    typedef enum logic [1:0] {RUN, DOWN, DEAD} state_t;
    logic [15:0] presc_cnt, ramp_cnt;
    logic [6:0]  pwm_cnt;
    logic        tick, period_end, strobe;
    assign tick       = presc_cnt == PRESC_MAX;
    assign period_end = tick & (pwm_cnt == 7'd126);
    assign strobe     = period_end & (ramp_cnt == RAMP_MAX);
    // shared prescaler, 127-step PWM counter and ramp divider
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            ramp_cnt  <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 16'd1;
            if (tick) pwm_cnt <= (pwm_cnt == 7'd126) ? '0 : pwm_cnt + 7'd1;
            if (period_end) ramp_cnt <= strobe ? '0 : ramp_cnt + 16'd1;
        end
    for (genvar c = 0; c < 2; c++) begin : ch
        logic [7:0] cmd;
        state_t     state, state_n;
        logic [6:0] cur_mag, mag_n, tgt_mag;
        logic       cur_dir, dir_n, tgt_dir;
        logic [7:0] dead_cnt, dead_n;
        logic       pwm_on, in1_n, in2_n, busy_n, in1, in2, busy;
        assign cmd = (c == 0) ? cmd_izq : cmd_der;
        // channel state, latched setpoint and registered bridge outputs
        always_ff @(posedge clk_clk or posedge reset_reset)
            if (reset_reset) begin
                state    <= RUN;
                cur_mag  <= '0;
                cur_dir  <= 1'b0;
                dead_cnt <= '0;
                tgt_mag  <= '0;
                tgt_dir  <= 1'b0;
                in1      <= 1'b0;
                in2      <= 1'b0;
                busy     <= 1'b0;
            end else begin
                state    <= state_n;
                cur_mag  <= mag_n;
                cur_dir  <= dir_n;
                dead_cnt <= dead_n;
                if (period_end) {tgt_dir, tgt_mag} <= cmd;
                in1      <= in1_n;
                in2      <= in2_n;
                busy     <= busy_n;
            end
        // decisions use the word being latched this period_end, so a new setpoint acts from the next period
        always_comb begin
            state_n = state;
            mag_n   = cur_mag;
            dir_n   = cur_dir;
            dead_n  = dead_cnt;
            if (period_end)
                case (state)
                    RUN:
                        if (strobe) begin
                            if (cmd[7] == cur_dir)
                                mag_n = (cur_mag < cmd[6:0]) ? cur_mag + 7'd1 :
                                        (cur_mag > cmd[6:0]) ? cur_mag - 7'd1 : cur_mag;
                            else if (cur_mag != '0)
                                state_n = DOWN;
                            else begin
                                state_n = DEAD;
                                dead_n  = DEAD_LD;
                            end
                        end
                    DOWN:
                        if (cmd[7] == cur_dir)
                            state_n = RUN;
                        else if (strobe) begin
                            mag_n = cur_mag - 7'd1;
                            if (cur_mag == 7'd1) begin
                                state_n = DEAD;
                                dead_n  = DEAD_LD;
                            end
                        end
                    DEAD:
                        if (dead_cnt == '0) begin
                            state_n = RUN;
                            dir_n   = cmd[7];
                        end else
                            dead_n = dead_cnt - 8'd1;
                    default: state_n = RUN;
                endcase
        end
        // PWM compare, direction steering with coast in DEAD, and busy flag
        always_comb begin
            pwm_on = pwm_cnt < cur_mag;
`ifdef MOTOR_PWM_BRAKE_EN
            in1_n  = (state != DEAD) & ((pwm_on & ~cur_dir) | ((state == RUN) & (cur_mag == '0)));
            in2_n  = (state != DEAD) & ((pwm_on & cur_dir) | ((state == RUN) & (cur_mag == '0)));
`else
            in1_n  = pwm_on & ~cur_dir & (state != DEAD);
            in2_n  = pwm_on & cur_dir & (state != DEAD);
`endif
            busy_n = (state != RUN) | (cur_mag != tgt_mag) | (cur_dir != tgt_dir);
        end
    end
    assign izq_in1  = ch[0].in1;
    assign izq_in2  = ch[0].in2;
    assign busy_izq = ch[0].busy;
    assign der_in1  = ch[1].in1;
    assign der_in2  = ch[1].in2;
    assign busy_der = ch[1].busy;
endmodule

// File: tb/tb_motor_pwm_bridge.sv
// tb_motor_pwm_bridge: per-period pulse-width scoreboard for motor_pwm_bridge (PRESC=1, RAMP_PERIODS=1, DEAD_PERIODS=2)
module tb_motor_pwm_bridge;
    logic       clk_clk = 1'b0, reset_reset = 1'b1;
    logic [7:0] cmd_izq = 8'h00, cmd_der = 8'h00;
    logic       izq_in1, izq_in2, der_in1, der_in2, busy_izq, busy_der;
    int checks = 0, errors = 0;
    int s = 0;
    int a1 [2], a2 [2];
    bit ov [2];
    typedef struct {int w1; int w2; bit b;} exp_t;
    exp_t q_izq [$], q_der [$];

    motor_pwm_bridge #(.PRESC(1), .RAMP_PERIODS(1), .DEAD_PERIODS(2)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cmd_izq(cmd_izq), .cmd_der(cmd_der),
        .izq_in1(izq_in1), .izq_in2(izq_in2),
        .der_in1(der_in1), .der_in2(der_in2),
        .busy_izq(busy_izq), .busy_der(busy_der)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int w1, input int w2, input bit b);
        exp_t e;
        e.w1 = w1; e.w2 = w2; e.b = b;
        if (c == 0) q_izq.push_back(e); else q_der.push_back(e);
    endtask

    task automatic score(input int c, input int p, input bit b);
        exp_t  e;
        string n = (c == 0) ? "izq" : "der";
        if ((c == 0 && q_izq.size() == 0) || (c == 1 && q_der.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s p%0d: got a period with no expectation queued, expected queued entry", n, p);
            return;
        end
        if (c == 0) e = q_izq.pop_front(); else e = q_der.pop_front();
        chk($sformatf("%s p%0d in1 width", n, p), a1[c], e.w1);
        chk($sformatf("%s p%0d in2 width", n, p), a2[c], e.w2);
        chk($sformatf("%s p%0d busy", n, p), int'(b), int'(e.b));
        chk($sformatf("%s p%0d in1&in2 overlap", n, p), int'(ov[c]), 0);
    endtask

    // monitor: accumulate each 127-clk output period, then score it
    always @(posedge clk_clk) begin
        #1;
        if (reset_reset) begin
            s = 0;
            a1 = '{0, 0}; a2 = '{0, 0}; ov = '{0, 0};
        end else begin
            a1[0] += int'(izq_in1); a2[0] += int'(izq_in2); ov[0] |= izq_in1 & izq_in2;
            a1[1] += int'(der_in1); a2[1] += int'(der_in2); ov[1] |= der_in1 & der_in2;
            if (s % 127 == 126) begin
                score(0, s / 127, busy_izq);
                score(1, s / 127, busy_der);
                a1 = '{0, 0}; a2 = '{0, 0}; ov = '{0, 0};
            end
            s++;
        end
    end

    task automatic wait_s(input int t);
        while (s < t) @(negedge clk_clk);
    endtask

    task automatic mid(input int n);
        wait_s(127 * n + 60);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("outputs in initial reset", int'({izq_in1, izq_in2, der_in1, der_in2, busy_izq, busy_der}), 0);
        cmd_izq = 8'h40;
        cmd_der = 8'h7F;
        for (int p = 0; p <= 69; p++) push(0, (p < 64) ? p : 64, 0, p > 0 && p < 64);
        for (int p = 0; p <= 130; p++) push(1, (p < 127) ? p : 127, 0, p > 0 && p < 127);
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        mid(69);
        cmd_izq = 8'h0A;
        for (int p = 70; p <= 125; p++) push(0, (p <= 123) ? 133 - p : 10, 0, p < 123);
        mid(125);
        cmd_izq = 8'h8A;
        for (int p = 126; p <= 135; p++) push(0, 136 - p, 0, 1'b1);
        for (int p = 136; p <= 137; p++) push(0, 0, 0, 1'b1);
        for (int p = 138; p <= 150; p++) push(0, 0, (p - 138 > 10) ? 10 : p - 138, p < 148);
        mid(130);
        cmd_der = 8'h00;
        for (int p = 131; p <= 257; p++) push(1, 257 - p, 0, p < 257);
        mid(150);
        cmd_izq = 8'h0A;
        for (int p = 151; p <= 156; p++) push(0, 0, 161 - p, 1'b1);
        mid(156);
        cmd_izq = 8'h8A;
        for (int p = 157; p <= 170; p++) push(0, 0, (p < 162) ? p - 152 : 10, p < 162);
        mid(170);
        cmd_izq = 8'hC0;
        for (int p = 171; p <= 257; p++) push(0, 0, (p < 224) ? p - 160 : 64, p < 224);
        wait_s(127 * 258 + 51);
        chk("izq_in2 at pwm_cnt 50 before reset", int'(izq_in2), 1);
        reset_reset = 1'b1;
        #1;
        chk("outputs right after async reset", int'({izq_in1, izq_in2, der_in1, der_in2, busy_izq, busy_der}), 0);
        chk("phase 1 scoreboard drained", q_izq.size() + q_der.size(), 0);
        @(negedge clk_clk);
        @(negedge clk_clk);
        cmd_izq = 8'h03;
        cmd_der = 8'h82;
        for (int p = 0; p <= 7; p++) push(0, (p < 3) ? p : 3, 0, p > 0 && p < 3);
        for (int p = 0; p <= 7; p++) push(1, 0, (p < 4) ? 0 : ((p - 3 > 2) ? 2 : p - 3), p > 0 && p < 5);
        reset_reset = 1'b0;
        wait_s(127 * 8);
        chk("phase 2 scoreboard drained", q_izq.size() + q_der.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
